fpu_divider_dp: RTL
===================

// Module: fpu_divider_dp
// PURPOSE
//  Sequential IEEE-754 double-precision divider, result = A / B: the inverse operation of the DP multiplier.
//  Uses restoring division, one quotient bit per clock, with a start/done handshake.
//  Sits beside fpu_multiplier_dp in the FPU datapath. Same result conventions:
//  truncation (no rounding), no overflow/underflow detection, 11-bit exponent arithmetic wraps mod 2^11.
// PARAMETERS
//  WIDTH  64  operand/result width; only 64 (1 sign, 11 exponent, 52 fraction) is supported
// PORTS
//  clk          in   1      single clock; all state changes on rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request; sampled only in IDLE
//  A            in   WIDTH  dividend, captured on the accepting edge
//  B            in   WIDTH  divisor, captured on the accepting edge
//  result       out  WIDTH  quotient; valid when done=1, held until the next done
//  done         out  1      one-cycle pulse: result updated
//  busy         out  1      high from the accepting edge until done asserts
//  div_by_zero  out  1      sticky per operation; updated together with result
// BEHAVIOUR
//  Reset:
//   - result=0, done=0, busy=0, div_by_zero=0, state=IDLE.
//   - Reset mid-operation aborts the division; no done pulse is produced.
//  Operand decode:
//   - Exponent field 0 means zero; denormals are flushed to zero.
//   - Exponent 0x7FF is not special-cased (treated as a normal number).
//   - sign = A[63]^B[63]. Ma = {1,A[51:0]}, Mb = {1,B[51:0]} (53 bits each).
//  FSM states: IDLE, DIV, NORM.
//   IDLE:
//    - start=1 and B exp==0: next edge result={sign,11'h7FF,52'b0}, div_by_zero=1, done=1. Stay in IDLE.
//    - else start=1 and A exp==0: next edge result={sign,63'b0}, div_by_zero=0, done=1. Stay in IDLE.
//    - else start=1: latch operands, R=Ma (54 bits), q=0, cnt=53, busy=1, go to DIV.
//   DIV (54 cycles, cnt 53..0), each edge:
//    - if R>=Mb then q[cnt]=1 and R=(R-Mb)<<1; else q[cnt]=0 and R=R<<1.
//    - cnt decrements; after the cnt=0 iteration go to NORM.
//   NORM (1 cycle); q = floor(Ma*2^53/Mb), range (2^52, 2^54):
//    - q[53]=1: frac=q[52:1], exp=Ea-Eb+1023.
//    - q[53]=0: frac=q[51:0], exp=Ea-Eb+1022.
//    - Register result={sign,exp[10:0],frac}, div_by_zero=0, done=1, busy=0, go to IDLE.
//  Latency:
//   - Normal path: done is high in the cycle after the 55th edge following the accepting edge.
//   - Zero/div-by-zero path: done is high after 1 edge.
//  Handshake:
//   - start is ignored while busy=1 (in DIV/NORM).
//   - done never coincides with busy=1.
//   - start may be asserted in the same cycle done is high; it is accepted (state is IDLE).
//  Simultaneous events: rst has priority over start and over every FSM transition.
// TESTING
//  1. 0x4018000000000000 / 0x4000000000000000 (6/2) -> result 0x4008000000000000; done exactly 55 edges after start.
//  2. 0x3FF0000000000000 / 0x3FF8000000000000 (1/1.5, q[53]=0 path) -> 0x3FE5555555555555 (truncated, not ...56).
//  3. 0xBFF0000000000000 / 0x3FE0000000000000 (-1/0.5) -> 0xC000000000000000; sign and exponent correct.
//  4. 0x3FF0000000000000 / 0x0 -> 0x7FF0000000000000, div_by_zero=1, done after 1 edge; next valid op clears the flag.
//  5. 0x8000000000000000 / 0x4014000000000000 (-0/5) -> 0x8000000000000000 after 1 edge.
//  6. start pulsed again while busy -> ignored, one done only; rst at DIV cycle 20 -> busy=0, done stays 0, result=0.

Source files
------------

// File: rtl/fpu_divider_dp.sv
// Sequential IEEE-754 double-precision divider (A / B), restoring division with one
// quotient bit per clock. Truncates; exponent arithmetic wraps mod 2^11.
module fpu_divider_dp #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int unsigned EW = 11;
  localparam int unsigned FW = 52;
  localparam int unsigned MW = 53;
  localparam int unsigned RW = 54;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;
  logic             sign_q, sign_d;
  logic [EW-1:0]    ea_q, ea_d;
  logic [EW-1:0]    eb_q, eb_d;
  logic [MW-1:0]    mb_q, mb_d;
  logic [RW-1:0]    r_q, r_d;
  logic [RW-1:0]    q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             in_sign;
  logic [EW-1:0]    in_ea, in_eb;
  logic [EW-1:0]    res_exp;
  logic [FW-1:0]    res_frac;

  assign in_sign = A[WIDTH-1] ^ B[WIDTH-1];
  assign in_ea   = A[FW +: EW];
  assign in_eb   = B[FW +: EW];

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    dz_d     = dz_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    mb_d     = mb_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    res_exp  = '0;
    res_frac = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (in_eb == '0) begin
            result_d = {in_sign, {EW{1'b1}}, {FW{1'b0}}};
            dz_d     = 1'b1;
            done_d   = 1'b1;
          end else if (in_ea == '0) begin
            result_d = {in_sign, {(WIDTH-1){1'b0}}};
            dz_d     = 1'b0;
            done_d   = 1'b1;
          end else begin
            sign_d  = in_sign;
            ea_d    = in_ea;
            eb_d    = in_eb;
            mb_d    = {1'b1, B[FW-1:0]};
            r_d     = {2'b01, A[FW-1:0]};
            q_d     = '0;
            cnt_d   = CW'(RW - 1);
            busy_d  = 1'b1;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        // Remainder stays below 2*Mb, so it always fits in 54 bits
        if (r_q >= {1'b0, mb_q}) begin
          q_d[cnt_q] = 1'b1;
          r_d        = (r_q - {1'b0, mb_q}) << 1;
        end else begin
          q_d[cnt_q] = 1'b0;
          r_d        = r_q << 1;
        end
        if (cnt_q == '0) state_d = NORM;
        else             cnt_d   = cnt_q - CW'(1);
      end
      NORM: begin
        if (q_q[RW-1]) begin
          res_frac = q_q[FW:1];
          res_exp  = ea_q - eb_q + EW'(1023);
        end else begin
          res_frac = q_q[FW-1:0];
          res_exp  = ea_q - eb_q + EW'(1022);
        end
        result_d = {sign_q, res_exp, res_frac};
        dz_d     = 1'b0;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      mb_q     <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      dz_q     <= dz_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      mb_q     <= mb_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result      = result_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign div_by_zero = dz_q;

endmodule
